// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter in front of the APB bridge's single AHB-side port.
// One transfer in flight at a time; out-of-window addresses and stalled bridges complete with error.
module apb_bridge_arbiter #(
    parameter int          NUM_M    = 3,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                  PCLK,
    input  logic                  Prst,
    input  logic [NUM_M-1:0]      m_req,
    input  logic [NUM_M-1:0]      m_write,
    input  logic [32*NUM_M-1:0]   m_addr,
    input  logic [32*NUM_M-1:0]   m_wdata,
    output logic [NUM_M-1:0]      m_done,
    output logic [NUM_M-1:0]      m_err,
    output logic [31:0]           m_rdata,
    output logic                  Hen,
    output logic                  Hwrite,
    output logic [31:0]           Haddr,
    output logic [31:0]           Hwdata,
    input  logic                  Hready,
    input  logic [31:0]           Hrdata
);

    localparam int              PW        = $clog2(NUM_M);
    localparam int              WW        = $clog2(TIMEOUT);
    localparam logic [PW:0]     LP_NM     = (PW+1)'(NUM_M);
    localparam logic [WW-1:0]   LP_WD_MAX = WW'(TIMEOUT-1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [PW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic [PW-1:0]      r_gnt, w_gnt_nxt;
    logic [WW-1:0]      r_wdog, w_wdog_nxt;
    logic               r_oow, w_oow_nxt;
    logic               w_hen_nxt, w_hwrite_nxt;
    logic [31:0]        w_haddr_nxt, w_hwdata_nxt, w_rdata_nxt;
    logic [NUM_M-1:0]   w_done_nxt, w_err_nxt;

    logic [2*NUM_M-1:0] w_req2;
    logic               w_any;
    logic [PW-1:0]      w_off, w_win, w_win_inc;
    logic [PW:0]        w_sum, w_sum_wr, w_sum_inc;
    logic               w_win_write;
    logic [31:0]        w_win_addr, w_win_wdata;
    logic [NUM_M-1:0]   w_gnt_oh;

    // Rotate requests so bit k is requester (rr_ptr+k) mod NUM_M; lowest set bit wins.
    assign w_req2 = {m_req, m_req} >> r_rr_ptr;

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int k = NUM_M-1; k >= 0; k--) begin
            if (w_req2[k]) begin
                w_any = 1'b1;
                w_off = PW'(k);
            end
        end
    end

    assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_sum_wr  = w_sum - LP_NM;
    assign w_win     = (w_sum >= LP_NM) ? w_sum_wr[PW-1:0] : w_sum[PW-1:0];
    assign w_sum_inc = {1'b0, w_win} + (PW+1)'(1);
    assign w_win_inc = (w_sum_inc == LP_NM) ? '0 : w_sum_inc[PW-1:0];

    always_comb begin
        w_win_write = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        w_gnt_oh    = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (w_win == PW'(i)) begin
                w_win_write = m_write[i];
                w_win_addr  = m_addr[32*i +: 32];
                w_win_wdata = m_wdata[32*i +: 32];
            end
            w_gnt_oh[i] = (r_gnt == PW'(i));
        end
    end

    always_ff @(posedge PCLK) begin
        if (Prst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_wdog   <= '0;
            r_oow    <= 1'b0;
            Hen      <= 1'b0;
            Hwrite   <= 1'b0;
            Haddr    <= '0;
            Hwdata   <= '0;
            m_done   <= '0;
            m_err    <= '0;
            m_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_wdog   <= w_wdog_nxt;
            r_oow    <= w_oow_nxt;
            Hen      <= w_hen_nxt;
            Hwrite   <= w_hwrite_nxt;
            Haddr    <= w_haddr_nxt;
            Hwdata   <= w_hwdata_nxt;
            m_done   <= w_done_nxt;
            m_err    <= w_err_nxt;
            m_rdata  <= w_rdata_nxt;
        end
    end

    // Every output is computed for the next state, so each is valid in the state it belongs to.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_gnt_nxt    = r_gnt;
        w_wdog_nxt   = r_wdog;
        w_oow_nxt    = r_oow;
        w_hen_nxt    = 1'b0;
        w_hwrite_nxt = Hwrite;
        w_haddr_nxt  = Haddr;
        w_hwdata_nxt = Hwdata;
        w_rdata_nxt  = m_rdata;
        w_done_nxt   = '0;
        w_err_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt    = w_win;
                    w_rr_ptr_nxt = w_win_inc;
                    w_wdog_nxt   = '0;
                    w_oow_nxt    = (w_win_addr[31:10] != '0);
                    w_state_nxt  = S_ISSUE;
                    // Out-of-window grants still pass through ISSUE, but with Hen held low.
                    if (w_win_addr[31:10] == '0) begin
                        w_hen_nxt    = 1'b1;
                        w_hwrite_nxt = w_win_write;
                        w_haddr_nxt  = w_win_addr;
                        w_hwdata_nxt = w_win_wdata;
                    end
                end
            end
            S_ISSUE: begin
                if (r_oow) begin
                    w_rdata_nxt = '0;
                    w_done_nxt  = w_gnt_oh;
                    w_err_nxt   = w_gnt_oh;
                    w_state_nxt = S_DONE;
                end else begin
                    w_wdog_nxt  = r_wdog + WW'(1);
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // wdog counts cycles since Hen, so a timeout reply lands TIMEOUT cycles after it.
                w_wdog_nxt = r_wdog + WW'(1);
                if (Hready) begin
                    w_rdata_nxt = Hwrite ? 32'h0 : Hrdata;
                    w_done_nxt  = w_gnt_oh;
                    w_state_nxt = S_DONE;
                end else if (r_wdog == LP_WD_MAX) begin
                    w_rdata_nxt = ERR_DATA;
                    w_done_nxt  = w_gnt_oh;
                    w_err_nxt   = w_gnt_oh;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
